// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - streaming 3x3 neighbourhood generator with two line buffers
// Optional window centre coordinates on window_x/window_y when WINDOW_COORD_EN is defined.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
  output logic [71:0] window_out,
  output logic        window_out_valid,
  output logic        frame_done
`ifdef WINDOW_COORD_EN
  ,
  output logic [11:0] window_x,
  output logic [11:0] window_y
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  typedef enum logic {
    FILL,
    ACTIVE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    win_q [0:8];
  logic [7:0]    win_d [0:8];
  logic [71:0]   wout_q, wout_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
`ifdef WINDOW_COORD_EN
  logic [11:0]   x_q, x_d;
  logic [11:0]   y_q, y_d;
`endif

  // Line storage: lb1 holds the previous line, lb0 the one before it.
  logic [7:0] lb0_q [0:IMG_WIDTH-1];
  logic [7:0] lb1_q [0:IMG_WIDTH-1];
  logic [7:0] lb0_rd, lb1_rd;
  logic       last_col, last_row;

  assign lb0_rd   = lb0_q[col_q];
  assign lb1_rd   = lb1_q[col_q];
  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    wout_d  = wout_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef WINDOW_COORD_EN
    x_d     = x_q;
    y_d     = y_q;
`endif
    if (pixel_in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      // Shift unconditionally; columns stale across a line wrap are masked by col >= 2.
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3+1];
        win_d[r*3 + 1] = win_q[r*3+2];
      end
      win_d[2] = lb0_rd;
      win_d[5] = lb1_rd;
      win_d[8] = pixel_in;

      case (state_q)
        FILL: begin
          if (last_col && row_q == RW'(1)) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (col_q >= CW'(2)) begin
            valid_d = 1'b1;
            for (int i = 0; i < 9; i++) wout_d[i*8 +: 8] = win_d[i];
`ifdef WINDOW_COORD_EN
            x_d = 12'(col_q) - 12'd1;
            y_d = 12'(row_q) - 12'd1;
`endif
          end
          if (last_col && last_row) begin
            state_d = FILL;
            done_d  = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      wout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef WINDOW_COORD_EN
      x_q     <= '0;
      y_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      wout_q  <= wout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef WINDOW_COORD_EN
      x_q     <= x_d;
      y_q     <= y_d;
`endif
    end
  end

  // Line buffers are deliberately not cleared; FILL hides any earlier contents.
  always_ff @(posedge clk) begin
    if (rstN && pixel_in_valid) begin
      lb0_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= pixel_in;
    end
  end

  assign window_out       = wout_q;
  assign window_out_valid = valid_q;
  assign frame_done       = done_q;
`ifdef WINDOW_COORD_EN
  assign window_x         = x_q;
  assign window_y         = y_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench for sobel_window_gen against a frame-array model
module tb_sobel_window_gen;
  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic [71:0] window_out;
  logic        window_out_valid;
  logic        frame_done;
`ifdef WINDOW_COORD_EN
  logic [11:0] window_x;
  logic [11:0] window_y;
`endif

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk              (clk),
    .rstN             (rstN),
    .pixel_in         (pixel_in),
    .pixel_in_valid   (pixel_in_valid),
    .window_out       (window_out),
    .window_out_valid (window_out_valid),
    .frame_done       (frame_done)
`ifdef WINDOW_COORD_EN
    ,
    .window_x         (window_x),
    .window_y         (window_y)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    logic        fd;
    int          x;
    int          y;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [71:0] win_log[$];
  logic [7:0]  img [H][W];
  int          mr = 0;
  int          mc = 0;
  int          win_cnt = 0;
  int          fd_cnt = 0;
  logic        acc_prev = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: keep the current frame as a 2-D array and cut the 3x3 block ending at (mr, mc).
  task automatic model_accept(input logic [7:0] d);
    exp_t e;
    img[mr][mc] = d;
    if (mr >= 2 && mc >= 2) begin
      e.w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.w[(r*3 + c)*8 +: 8] = img[mr-2+r][mc-2+c];
      e.fd = (mr == H-1 && mc == W-1);
      e.x  = mc - 1;
      e.y  = mr - 1;
      q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    pixel_in_valid = v;
    pixel_in       = d;
    @(posedge clk);
    if (v && rstN) model_accept(d);
    #1;
  endtask

  // mode 0: pattern continuous, 1: pattern with random stalls, 2: random pixels continuous
  task automatic send_frame(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (mode == 1)
          while ($urandom_range(0, 1) == 1) drive(1'b0, 8'($urandom));
        if (mode == 2) drive(1'b1, 8'($urandom));
        else           drive(1'b1, 8'(r*16 + c));
      end
  endtask

  always @(posedge clk) acc_prev <= pixel_in_valid && rstN;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (window_out_valid) begin
      exp_t e;
      win_cnt++;
      win_log.push_back(window_out);
      chk("valid_follows_accept", {71'b0, acc_prev}, 72'd1);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got %h expected none", window_out);
      end else begin
        e = q.pop_front();
        chk("window", window_out, e.w);
        chk("frame_done", {71'b0, frame_done}, {71'b0, e.fd});
`ifdef WINDOW_COORD_EN
        chk("window_x", {60'b0, window_x}, 72'(e.x));
        chk("window_y", {60'b0, window_y}, 72'(e.y));
`endif
      end
    end else begin
      chk("frame_done_without_valid", {71'b0, frame_done}, 72'd0);
    end
  end

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_window_out"}, window_out, 72'd0);
    chk({tag, "_valid"}, {71'b0, window_out_valid}, 72'd0);
    chk({tag, "_frame_done"}, {71'b0, frame_done}, 72'd0);
`ifdef WINDOW_COORD_EN
    chk({tag, "_window_x"}, {60'b0, window_x}, 72'd0);
    chk({tag, "_window_y"}, {60'b0, window_y}, 72'd0);
`endif
  endtask

  task automatic check_phase(input string tag, input int w0, input int f0, input int nw, input int nf);
    chk({tag, "_windows"}, 72'(win_cnt - w0), 72'(nw));
    chk({tag, "_frame_done_count"}, 72'(fd_cnt - f0), 72'(nf));
    chk({tag, "_pending"}, 72'(q.size()), 72'd0);
  endtask

  int w0, f0, base;

  initial begin
    rstN           = 1'b0;
    pixel_in_valid = 1'b0;
    pixel_in       = '0;
    repeat (3) drive(1'b0, 8'h00);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Continuous frame with the row*16+col pattern
    w0 = win_cnt; f0 = fd_cnt; base = win_log.size();
    send_frame(0);
    repeat (3) drive(1'b0, 8'h00);
    check_phase("continuous", w0, f0, 24, 1);
    if (win_log.size() >= base + 7) begin
      chk("first_window", win_log[base], 72'h22_21_20_12_11_10_02_01_00);
      chk("line_boundary_window", win_log[base+6], 72'h32_31_30_22_21_20_12_11_10);
    end else begin
      checks++;
      errors++;
      $display("FAIL window_log_short: got %0d expected at least %0d", win_log.size() - base, 7);
    end

    // Same frame with random stalls
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(1);
    repeat (3) drive(1'b0, 8'h00);
    check_phase("stalls", w0, f0, 24, 1);

    // Back-to-back frames, second one random pixels
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(0);
    send_frame(2);
    repeat (3) drive(1'b0, 8'h00);
    check_phase("back_to_back", w0, f0, 48, 2);

    // Partial frame up to (3,4), then a one-cycle reset with a pixel offered
    w0 = win_cnt; f0 = fd_cnt;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c <= 4) drive(1'b1, 8'(r*16 + c));
    rstN = 1'b0;
    drive(1'b1, 8'hFF);
    rstN = 1'b1;
    pixel_in_valid = 1'b0;
    check_phase("partial", w0, f0, 9, 0);
    check_outputs_zero("mid_reset");
    mr = 0;
    mc = 0;
    w0 = win_cnt; f0 = fd_cnt;
    send_frame(0);
    repeat (3) drive(1'b0, 8'h00);
    check_phase("after_reset", w0, f0, 24, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
